// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register file geometry and the writeback entry format
// used by the writeback queue and the decode stage.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fwd_match.sv
// DEPTH-way address compare over the pending writeback entries; the youngest
// matching entry (closest behind the write pointer) supplies the forwarded value.
module regfile_wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [DEPTH-1:0][XLEN-1:0]   datas,
    input  logic [PTR_W-1:0]             wr_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [ADDR_W-1:0]            lookup_addr,
    output logic                         hit,
    output logic [XLEN-1:0]              data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match written is the youngest one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = wr_ptr - PTR_W'(k + 1);
            if (CNT_W'(k) < count && lookup_addr != '0 && addrs[idx] == lookup_addr) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_writeback_queue.sv
// Buffers writeback requests and drains them in order into the regfile write port,
// one per cycle, with a two-port forwarding lookup over the not-yet-committed entries.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           wb_valid,
    output logic                           wb_ready,
    input  logic [ADDR_W-1:0]              wb_addr,
    input  logic [XLEN-1:0]                wb_data,
    output logic                           rf_write_enable,
    output logic [ADDR_W-1:0]              rf_write_addr,
    output logic [XLEN-1:0]                rf_write_data,
    input  logic [ADDR_W-1:0]              lookup_addr1,
    input  logic [ADDR_W-1:0]              lookup_addr2,
    output logic                           fwd_hit1,
    output logic [XLEN-1:0]                fwd_data1,
    output logic                           fwd_hit2,
    output logic [XLEN-1:0]                fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]     pending_count
);
    import riscv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             push, pop;
    wb_entry_t        head;

    logic [DEPTH-1:0][ADDR_W-1:0] addrs;
    logic [DEPTH-1:0][XLEN-1:0]   datas;
    logic                         hit1_raw, hit2_raw;
    logic [XLEN-1:0]              data1_raw, data2_raw;

    assign wb_ready        = reset_n && (count < CNT_W'(DEPTH));
    assign rf_write_enable = reset_n && (count != '0);
    // Writes to x0 complete the handshake but never occupy an entry.
    assign push            = wb_valid && wb_ready && (wb_addr != REG_ZERO);
    assign pop             = rf_write_enable;

    assign head          = mem[rd_ptr];
    assign rf_write_addr = rf_write_enable ? head.addr : '0;
    assign rf_write_data = rf_write_enable ? head.data : '0;
    assign pending_count = count;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Payload storage carries no reset; validity lives entirely in count/pointers.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= '{addr: wb_addr, data: wb_data};
    end

    always_comb begin
        addrs = '0;
        datas = '0;
        for (int i = 0; i < DEPTH; i++) begin
            addrs[i] = mem[i].addr;
            datas[i] = mem[i].data;
        end
    end

    regfile_wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_W(ADDR_W)) u_match1 (
        .addrs(addrs), .datas(datas), .wr_ptr(wr_ptr), .count(count),
        .lookup_addr(lookup_addr1), .hit(hit1_raw), .data(data1_raw)
    );

    regfile_wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN), .ADDR_W(ADDR_W)) u_match2 (
        .addrs(addrs), .datas(datas), .wr_ptr(wr_ptr), .count(count),
        .lookup_addr(lookup_addr2), .hit(hit2_raw), .data(data2_raw)
    );

    assign fwd_hit1  = reset_n && hit1_raw;
    assign fwd_data1 = reset_n ? data1_raw : '0;
    assign fwd_hit2  = reset_n && hit2_raw;
    assign fwd_data2 = reset_n ? data2_raw : '0;
endmodule
